// File: rtl/shift_pkg.sv
// Shared definitions for the shift command path: default width, direction
// encoding and the packed {data, amt, dir} command bundle.
package shift_pkg;

    localparam int SHIFT_N = 8;
    localparam int AMT_W   = $clog2(SHIFT_N);
    localparam int CMD_W   = SHIFT_N + AMT_W + 1;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef struct packed {
        logic [SHIFT_N-1:0] data;
        logic [AMT_W-1:0]   amt;
        logic               dir;
    } shift_cmd_t;

    // Packed command width for an arbitrary data width n.
    function automatic int cmd_width(input int n);
        return n + $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/shift_cmd_queue.sv
// DEPTH-entry FIFO of shift commands feeding a combinational barrel shifter;
// the head command is presented directly on sh_data/sh_amt/sh_dir.
module shift_cmd_queue
    import shift_pkg::*;
#(
    parameter int N     = SHIFT_N,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             in_data,
    input  logic [$clog2(N)-1:0]     in_amt,
    input  logic                     in_dir,
    output logic                     sh_valid,
    input  logic                     sh_ready,
    output logic [N-1:0]             sh_data,
    output logic [$clog2(N)-1:0]     sh_amt,
    output logic                     sh_dir,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW     = $clog2(N);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int CMD_BITS = cmd_width(N);

    logic [CMD_BITS-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CMD_BITS-1:0] head;
    logic                push, pop;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high. in_ready/sh_valid depend only on registered occupancy, so a
    // pop never opens a slot for a push in the same cycle.
    assign in_ready = (count_q != CNT_W'(DEPTH));
    assign sh_valid = (count_q != '0);
    assign push     = in_valid & in_ready;
    assign pop      = sh_valid & sh_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left unreset; only occupancy makes it visible.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= {in_data, in_amt, in_dir};
    end

    assign head    = mem_q[rd_ptr_q];
    assign sh_data = sh_valid ? head[CMD_BITS-1 -: N] : '0;
    assign sh_amt  = sh_valid ? head[AW:1]            : '0;
    assign sh_dir  = sh_valid ? head[0]               : DIR_LEFT;
    assign count   = count_q;

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Directed bench for shift_cmd_queue: accepted commands go into an expected
// queue; a negedge monitor checks occupancy flags and head contents.
module tb_shift_cmd_queue;

    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(N);
    localparam int W     = N + AW + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N-1:0]    in_data = '0;
    logic [AW-1:0]   in_amt = '0;
    logic            in_dir = 1'b0;
    logic            sh_valid;
    logic            sh_ready = 1'b0;
    logic [N-1:0]    sh_data;
    logic [AW-1:0]   sh_amt;
    logic            sh_dir;
    logic [$clog2(DEPTH):0] count;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    shift_cmd_queue #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt), .in_dir(in_dir),
        .sh_valid(sh_valid), .sh_ready(sh_ready),
        .sh_data(sh_data), .sh_amt(sh_amt), .sh_dir(sh_dir),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every negedge compare DUT state against the expected queue.
    always @(negedge clk) begin
        check("count", 32'(count), 32'(exp_q.size()));
        check("in_ready", 32'(in_ready), 32'(exp_q.size() != DEPTH));
        check("sh_valid", 32'(sh_valid), 32'(exp_q.size() != 0));
        if (sh_valid) begin
            if (exp_q.size() == 0) begin
                check("underflow", 32'(sh_valid), 32'(0));
            end else begin
                check("head", 32'({sh_data, sh_amt, sh_dir}), 32'(exp_q[0]));
                if (sh_ready && !flush) void'(exp_q.pop_front());
            end
        end else begin
            check("idle_zero", 32'({sh_data, sh_amt, sh_dir}), 32'(0));
        end
    end

    // One cycle of stimulus; acceptance is decided from the expected queue
    // before the monitor's negedge pop, matching registered in_ready.
    task automatic cyc(input logic v, input logic [N-1:0] d, input logic [AW-1:0] a,
                       input logic dr, input logic rdy, input logic fl);
        logic acc;
        in_valid = v; in_data = d; in_amt = a; in_dir = dr;
        sh_ready = rdy; flush = fl;
        acc = v && !fl && (exp_q.size() != DEPTH);
        @(posedge clk);
        if (fl) exp_q.delete();
        else if (acc) exp_q.push_back({d, a, dr});
        #1;
        in_valid = 1'b0; sh_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    logic [N-1:0]  vd [4];
    logic [AW-1:0] va [4];
    logic          vr [4];

    initial begin
        vd[0] = 8'hAA; va[0] = 3'd1; vr[0] = 1'b0;
        vd[1] = 8'h0F; va[1] = 3'd2; vr[1] = 1'b0;
        vd[2] = 8'h81; va[2] = 3'd1; vr[2] = 1'b1;
        vd[3] = 8'hC3; va[3] = 3'd3; vr[3] = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Single push then hold with sh_ready low.
        cyc(1'b1, 8'b10101010, 3'd1, 1'b0, 1'b0, 1'b0);
        idle(5);
        drain();

        // Fill, attempt a fifth push, then pop in order.
        for (int i = 0; i < 4; i++) cyc(1'b1, vd[i], va[i], vr[i], 1'b0, 1'b0);
        cyc(1'b1, 8'h55, 3'd7, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        idle(1);

        // Steady push+pop at occupancy 2; pointers wrap.
        cyc(1'b1, 8'h11, 3'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 3'd1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            cyc(1'b1, 8'(8'h30 + i), 3'(i), 1'(i), 1'b1, 1'b0);
        drain();

        // Full with pop and push together: push rejected.
        for (int i = 0; i < 4; i++) cyc(1'b1, vd[3-i], va[3-i], vr[3-i], 1'b0, 1'b0);
        cyc(1'b1, 8'hEE, 3'd5, 1'b0, 1'b1, 1'b0);
        idle(1);
        drain();

        // Flush with in_valid high: nothing from that cycle is stored.
        for (int i = 0; i < 3; i++) cyc(1'b1, vd[i], va[i], vr[i], 1'b0, 1'b0);
        cyc(1'b1, 8'h77, 3'd6, 1'b1, 1'b1, 1'b1);
        idle(2);
        cyc(1'b1, 8'h99, 3'd4, 1'b1, 1'b0, 1'b0);
        drain();

        // Asynchronous reset mid-burst at count 3.
        for (int i = 0; i < 3; i++) cyc(1'b1, vd[i], va[i], vr[i], 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'(0));
        check("rst_valid", 32'(sh_valid), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_head", 32'({sh_data, sh_amt, sh_dir}), 32'(0));
        exp_q.delete();
        #1 rst_n = 1'b1;
        idle(2);
        cyc(1'b1, 8'h5A, 3'd2, 1'b0, 1'b0, 1'b0);
        drain();

        check("final_empty", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
